fork_eager_buffer: RTL and testbench
====================================

FORK_EAGER_BUFFER -- requirements
Module: fork_eager_buffer

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of the data token.
REQ-002: Parameter NUM_READYS, default 2, number of fork consumers (at least 1).
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: data_in  input  DATA_WIDTH  upstream token data.
REQ-006: valid_in  input  1  upstream token valid.
REQ-007: ready_in  output  1  buffer can accept a token this cycle.
REQ-008: data_out  output  DATA_WIDTH  head token data, shared by all consumers.
REQ-009: valid_out  output  NUM_READYS  per-consumer token valid.
REQ-010: ready_out  input  NUM_READYS  per-consumer ready.
REQ-011: fork_mask  input  NUM_READYS  1 = consumer i participates in the fork; quasi-static configuration.

Function
REQ-012: The block SHALL be a 2-entry FIFO (head slot plus skid slot), with occupancy count 0..2.
REQ-013: Push SHALL occur on valid_in && ready_in; ready_in SHALL equal (count < 2), with no combinational path from ready_out or valid_in.
REQ-014: Latency SHALL be 1 cycle: a token pushed at edge N is presented on data_out/valid_out after edge N.
REQ-015: Per-consumer state done[i] SHALL record that consumer i has already taken the current head token.
REQ-016: valid_out[i] SHALL equal head_valid && fork_mask[i] && !done[i].
REQ-017: Consumer i takes the head on valid_out[i] && ready_out[i]; done[i] SHALL set at that edge unless the head retires at the same edge.
REQ-018: The head SHALL retire (pop) when head_valid and, for every i, (!fork_mask[i] || done[i] || ready_out[i]).
REQ-019: On retire, all done bits SHALL clear and the skid entry, if present, SHALL become the head at the same edge.
REQ-020: Eager behaviour: a ready consumer SHALL never be stalled by a non-ready sibling; each enabled consumer receives each token exactly once.
REQ-021: Push and pop at the same edge with count 1 SHALL leave count 1, with the new token at the head.
REQ-022: Push and pop at the same edge with count 2 cannot occur, because ready_in = 0 when count is 2.
REQ-023: fork_mask all zero SHALL act as a sink: a valid head retires at the first edge it is valid.
REQ-024: Tokens SHALL leave in FIFO order, and data_out SHALL be stable while head_valid && !retire.
REQ-025: A mask change while a token is held SHALL be honoured combinationally: newly masked consumers no longer block retire, and newly unmasked consumers receive the remaining head if not done.

Reset
REQ-026: When rst is asserted, count, all done bits and both data slots SHALL go to 0 asynchronously.
REQ-027: During reset, valid_out SHALL be 0 and ready_in SHALL be 1.
REQ-028: Reset mid-operation SHALL discard all held tokens.
REQ-029: The first push SHALL be possible at the first clk edge after rst deasserts.

Verification
REQ-030: Directed scenarios the bench SHALL cover:
- Mask 2'b11, both ready, push 0xA5 -> valid_out = 2'b11 one cycle later; retire after 1 cycle; ready_in stays 1; continuous streaming at 1 token/cycle.
- Mask 2'b11, ready_out = 2'b01 for 3 cycles then 2'b10 -> consumer 0 sees exactly one handshake; valid_out = 2'b10 thereafter; retire when ready_out[1] = 1.
- Mask 2'b11, ready_out = 0, push 0x11, 0x22, 0x33 back-to-back -> ready_in = 0 after 2 pushes; 0x33 held upstream; then all ready -> outputs 0x11, 0x22, 0x33 in order.
- Mask 2'b00, push 4 tokens -> valid_out stays 0; each token retires; ready_in never drops.
- Mask 2'b10, consumer 0 ready_out = 0 -> valid_out[0] stays 0; tokens flow through consumer 1 only.
- Count 2 with done[0] = 1, assert rst mid-cycle -> valid_out = 0 and ready_in = 1 immediately; no stale token after release.

Source files
------------

// File: rtl/fork_eager_buffer.sv
// fork_eager_buffer
//   Two-entry FIFO (head slot plus skid slot) feeding an eager fork. Each
//   enabled consumer takes the head token exactly once, independently of its
//   siblings; the head retires once every enabled consumer has taken it (or
//   takes it in the current cycle). ready_in depends only on registered
//   occupancy, so upstream sees no combinational path from the consumers.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   data_in    upstream token data
//   valid_in   upstream token valid
//   ready_in   buffer can accept a token this cycle (occupancy < 2)
//   data_out   head token data, shared by all consumers
//   valid_out  per-consumer token valid
//   ready_out  per-consumer ready
//   fork_mask  per-consumer enable (quasi-static configuration)
module fork_eager_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READYS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_READYS-1:0] valid_out,
  input  logic [NUM_READYS-1:0] ready_out,
  input  logic [NUM_READYS-1:0] fork_mask
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [NUM_READYS-1:0] done_q, done_d;

  logic                  head_valid;
  logic                  push;
  logic                  retire;
  logic [NUM_READYS-1:0] take;

  assign head_valid = (count_q != 2'd0);
  assign ready_in   = (count_q != 2'd2);
  assign push       = valid_in && ready_in;
  assign data_out   = head_q;
  assign valid_out  = {NUM_READYS{head_valid}} & fork_mask & ~done_q;
  assign take       = valid_out & ready_out;

  // A consumer no longer blocks the head if it is masked off, already served,
  // or is being served right now.
  assign retire = head_valid && ((~fork_mask | done_q | ready_out) == '1);

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    done_d  = done_q;

    if (retire) begin
      done_d = '0;
    end else begin
      done_d = done_q | take;
    end

    unique case ({push, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Slot movement. Push with retire only happens at count 1 (ready_in is low
    // at count 2), so the incoming token goes straight into the head slot.
    if (retire) begin
      if (count_q == 2'd2) begin
        head_d = skid_q;
      end else if (push) begin
        head_d = data_in;
      end
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d = data_in;
      end else begin
        skid_d = data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      skid_q  <= '0;
      done_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fork_eager_buffer.sv
module tb_fork_eager_buffer;

  localparam int W = 32;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] data_out;
  logic [N-1:0] valid_out;
  logic [N-1:0] ready_out;
  logic [N-1:0] fork_mask;

  fork_eager_buffer #(.DATA_WIDTH(W), .NUM_READYS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .fork_mask (fork_mask)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: queue of held tokens plus "already delivered" flags for
  // the token at the front of the queue.
  logic [W-1:0] mq[$];
  logic [N-1:0] delivered;

  // DUT-observed handshakes, recorded per consumer.
  logic [W-1:0] seen0[$];
  logic [W-1:0] seen1[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    delivered = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare the DUT's
  // outputs with the model, then advance the model to the next rising edge.
  task automatic step(input logic [W-1:0] d, input logic v,
                      input logic [N-1:0] r, input logic [N-1:0] m);
    logic         hv;
    logic         full;
    logic         all_clear;
    logic [N-1:0] exp_vo;
    @(negedge clk);
    data_in   = d;
    valid_in  = v;
    ready_out = r;
    fork_mask = m;
    #1;
    hv   = (mq.size() > 0);
    full = (mq.size() >= 2);
    exp_vo = '0;
    all_clear = hv;
    for (int i = 0; i < N; i++) begin
      exp_vo[i] = hv && m[i] && !delivered[i];
      if (m[i] && !delivered[i] && !r[i]) all_clear = 1'b0;
    end
    check("ready_in", 64'(ready_in), 64'(!full));
    check("valid_out", 64'(valid_out), 64'(exp_vo));
    if (hv) check("data_out", 64'(data_out), 64'(mq[0]));
    if (valid_out[0] && ready_out[0]) seen0.push_back(data_out);
    if (valid_out[1] && ready_out[1]) seen1.push_back(data_out);
    if (all_clear) begin
      void'(mq.pop_front());
      delivered = '0;
    end else begin
      delivered = delivered | (exp_vo & r);
    end
    if (v && !full) mq.push_back(d);
  endtask

  initial begin
    logic [N-1:0] rmask;
    rst       = 1'b1;
    data_in   = '0;
    valid_in  = 1'b0;
    ready_out = '0;
    fork_mask = 2'b11;
    model_reset();

    #12;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd1);
    check("rst_data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: both ready, single token then continuous streaming.
    step(32'hA5, 1'b1, 2'b11, 2'b11);
    step(32'h0, 1'b0, 2'b11, 2'b11);
    check("s1_a5_out", 64'(seen0.size() == 1 && seen1.size() == 1 && seen0[0] == 32'hA5), 64'd1);
    step(32'h0, 1'b0, 2'b11, 2'b11);
    for (int i = 0; i < 8; i++) step(32'h100 + 32'(i), 1'b1, 2'b11, 2'b11);
    step(32'h0, 1'b0, 2'b11, 2'b11);
    check("s1_stream_cnt", 64'(seen1.size()), 64'd9);

    // Scenario 2: consumer 0 served early, consumer 1 later.
    seen0.delete();
    seen1.delete();
    step(32'h5C, 1'b1, 2'b00, 2'b11);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 2'b01, 2'b11);
    check("s2_c0_once", 64'(seen0.size()), 64'd1);
    check("s2_vo_10", 64'(valid_out), 64'(2'b10));
    step(32'h0, 1'b0, 2'b10, 2'b11);
    step(32'h0, 1'b0, 2'b11, 2'b11);
    check("s2_c1_once", 64'(seen1.size()), 64'd1);

    // Scenario 3: fill to two, third token held upstream, then drain in order.
    seen0.delete();
    seen1.delete();
    step(32'h11, 1'b1, 2'b00, 2'b11);
    step(32'h22, 1'b1, 2'b00, 2'b11);
    step(32'h33, 1'b1, 2'b00, 2'b11);
    check("s3_full", 64'(ready_in), 64'd0);
    step(32'h33, 1'b1, 2'b11, 2'b11);
    step(32'h33, 1'b1, 2'b11, 2'b11);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 2'b11, 2'b11);
    check("s3_cnt", 64'(seen0.size()), 64'd3);
    if (seen0.size() == 3) begin
      check("s3_ord0", 64'(seen0[0]), 64'h11);
      check("s3_ord1", 64'(seen0[1]), 64'h22);
      check("s3_ord2", 64'(seen0[2]), 64'h33);
    end

    // Scenario 4: all-zero mask acts as a sink.
    for (int i = 0; i < 4; i++) step(32'h200 + 32'(i), 1'b1, 2'($urandom_range(0, 3)), 2'b00);
    step(32'h0, 1'b0, 2'b00, 2'b00);
    check("s4_empty", 64'(mq.size()), 64'd0);

    // Scenario 5: only consumer 1 enabled, consumer 0 never ready.
    seen0.delete();
    seen1.delete();
    for (int i = 0; i < 10; i++)
      step(32'h300 + 32'(i), 1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 1'b0}, 2'b10);
    for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 2'b10, 2'b10);
    check("s5_c0_none", 64'(seen0.size()), 64'd0);

    // Scenario 6: reset with two tokens held and consumer 0 already served.
    step(32'hAA, 1'b1, 2'b00, 2'b11);
    step(32'hBB, 1'b1, 2'b00, 2'b11);
    step(32'h0, 1'b0, 2'b01, 2'b11);
    @(negedge clk);
    ready_out = 2'b00;
    #2;
    check("s6_pre_vo", 64'(valid_out), 64'(2'b10));
    rst = 1'b1;
    #1;
    check("s6_rst_vo", 64'(valid_out), 64'd0);
    check("s6_rst_rdy", 64'(ready_in), 64'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(32'h0, 1'b0, 2'b11, 2'b11);
    step(32'hCC, 1'b1, 2'b00, 2'b11);
    step(32'h0, 1'b0, 2'b11, 2'b11);

    // Randomised traffic, including mask changes while a token is held.
    rmask = 2'b11;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rmask = 2'($urandom_range(0, 3));
      step($urandom, 1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), rmask);
    end
    for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 2'b11, 2'b11);
    check("final_empty", 64'(valid_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
